// File: rtl/alu_addsub_seq_module.sv
// Multi-cycle signed matrix add/subtract unit for the arithmetic coprocessor.
// Processes LANES elements per beat, with optional saturation and a sticky overflow flag.
module alu_addsub_seq_module #(
   parameter int DATA_W = 8,
   parameter int ELEMS  = 25,
   parameter int LANES  = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      op,
   input  logic                      sat_en,
   input  logic [ELEMS*DATA_W-1:0]   A_flat,
   input  logic [ELEMS*DATA_W-1:0]   B_flat,
   output logic [ELEMS*DATA_W-1:0]   C_flat,
   output logic                      overflow_flag,
   output logic                      busy,
   output logic                      done
);

   localparam int BEATS  = (ELEMS + LANES - 1) / LANES;
   localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int FLAT_W = ELEMS * DATA_W;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    beat_q, beat_d;
   logic [FLAT_W-1:0]   a_q, a_d;
   logic [FLAT_W-1:0]   b_q, b_d;
   logic [FLAT_W-1:0]   c_q, c_d;
   logic                op_q, op_d;
   logic                sat_q, sat_d;
   logic                ovf_q, ovf_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [DATA_W:0]     lane_res;
   int                  idx;

   // Returns {overflow, result}; with sign-extended DATA_W+1 arithmetic the
   // result overflowed exactly when the two top bits of the wide sum disagree.
   function automatic logic [DATA_W:0] elem_op(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic              sub,
                                                input logic              sat);
      logic [DATA_W:0]   ea;
      logic [DATA_W:0]   eb;
      logic [DATA_W:0]   r;
      logic [DATA_W-1:0] res;
      logic              ovf;
      ea  = {a[DATA_W-1], a};
      eb  = {b[DATA_W-1], b};
      r   = sub ? (ea - eb) : (ea + eb);
      ovf = r[DATA_W] ^ r[DATA_W-1];
      res = r[DATA_W-1:0];
      if (sat && ovf) begin
         res = a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      end
      return {ovf, res};
   endfunction

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      op_d     = op_q;
      sat_d    = sat_q;
      ovf_d    = ovf_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      lane_res = '0;
      idx      = 0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               beat_d  = '0;
               a_d     = A_flat;
               b_d     = B_flat;
               op_d    = op;
               sat_d   = sat_en;
               ovf_d   = 1'b0;
               busy_d  = 1'b1;
            end
         end
         RUN: begin
            // Lanes past the last element on a partial final beat write nothing.
            for (int l = 0; l < LANES; l++) begin
               idx = int'(beat_q) * LANES + l;
               if (idx < ELEMS) begin
                  lane_res = elem_op(a_q[idx*DATA_W +: DATA_W], b_q[idx*DATA_W +: DATA_W],
                                     op_q, sat_q);
                  c_d[idx*DATA_W +: DATA_W] = lane_res[DATA_W-1:0];
                  ovf_d = ovf_d | lane_res[DATA_W];
               end
            end
            if (beat_q == CNT_W'(BEATS - 1)) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               beat_d = beat_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         beat_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         op_q    <= 1'b0;
         sat_q   <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         op_q    <= op_d;
         sat_q   <= sat_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign C_flat        = c_q;
   assign overflow_flag = ovf_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_alu_addsub_seq_module.sv
// Directed self-checking bench for alu_addsub_seq_module: default 25x5 instance
// plus a 9-element, 4-lane instance exercising a partial final beat.
module tb_alu_addsub_seq_module;

   logic          clk;
   logic          rst_n;

   logic          start;
   logic          op;
   logic          sat_en;
   logic [199:0]  a_flat;
   logic [199:0]  b_flat;
   logic [199:0]  c_flat;
   logic          ovf;
   logic          busy;
   logic          done;

   logic          start2;
   logic [71:0]   a2_flat;
   logic [71:0]   b2_flat;
   logic [71:0]   c2_flat;
   logic          ovf2;
   logic          busy2;
   logic          done2;

   int            assert_cnt;
   int            fail_cnt;

   alu_addsub_seq_module dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .op            (op),
      .sat_en        (sat_en),
      .A_flat        (a_flat),
      .B_flat        (b_flat),
      .C_flat        (c_flat),
      .overflow_flag (ovf),
      .busy          (busy),
      .done          (done)
   );

   alu_addsub_seq_module #(.DATA_W(8), .ELEMS(9), .LANES(4)) dut2 (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start2),
      .op            (1'b0),
      .sat_en        (1'b0),
      .A_flat        (a2_flat),
      .B_flat        (b2_flat),
      .C_flat        (c2_flat),
      .overflow_flag (ovf2),
      .busy          (busy2),
      .done          (done2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [7:0] c_elem(input int i);
      return c_flat[i*8 +: 8];
   endfunction

   function automatic logic [7:0] c2_elem(input int i);
      return c2_flat[i*8 +: 8];
   endfunction

   task automatic set_all(input logic [7:0] av, input logic [7:0] bv);
      for (int i = 0; i < 25; i++) begin
         a_flat[i*8 +: 8] = av;
         b_flat[i*8 +: 8] = bv;
      end
   endtask

   // Operands are scrambled right after the accept edge to prove they were latched.
   task automatic start_op(input logic op_v, input logic sat_v);
      @(negedge clk);
      start  = 1'b1;
      op     = op_v;
      sat_en = sat_v;
      @(posedge clk);
      #1;
      start  = 1'b0;
      a_flat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      b_flat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      op     = ~op_v;
      sat_en = ~sat_v;
   endtask

   task automatic wait_done(output int cycles);
      cycles = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst_n   = 1'b0;
      start   = 1'b0;
      start2  = 1'b0;
      op      = 1'b0;
      sat_en  = 1'b0;
      a_flat  = '0;
      b_flat  = '0;
      a2_flat = '0;
      b2_flat = '0;
      #23;
      assert_cnt++;
      if ({c_flat, ovf, busy, done} !== 203'd0) begin
         fail_cnt++;
         $display("[TB] FAIL reset_dut: c=%h ovf=%b busy=%b done=%b, required all 0",
                  c_flat, ovf, busy, done);
      end
      assert_cnt++;
      if ({c2_flat, ovf2, busy2, done2} !== 75'd0) begin
         fail_cnt++;
         $display("[TB] FAIL reset_dut2: c=%h ovf=%b busy=%b done=%b, required all 0",
                  c2_flat, ovf2, busy2, done2);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_params;
      int cycles;
      logic [7:0] exp;
      for (int i = 0; i < 9; i++) begin
         a2_flat[i*8 +: 8] = 8'(i);
         b2_flat[i*8 +: 8] = 8'd1;
      end
      @(negedge clk);
      start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      cycles = -1;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         @(posedge clk);
         #1;
         if (cyc <= 3) begin
            for (int e = 0; e < 9; e++) begin
               exp = (e < cyc * 4) ? 8'(e + 1) : 8'd0;
               assert_cnt++;
               if (c2_elem(e) !== exp) begin
                  fail_cnt++;
                  $display("[TB] FAIL params_beat%0d_elem%0d: got %h, required %h",
                           cyc, e, c2_elem(e), exp);
               end
            end
         end
         if (done2) begin
            cycles = cyc;
            break;
         end
      end
      assert_cnt++;
      if (cycles !== 3) begin
         fail_cnt++;
         $display("[TB] FAIL params_latency: got %0d cycles, required 3", cycles);
      end
      assert_cnt++;
      if (ovf2 !== 1'b0) begin
         fail_cnt++;
         $display("[TB] FAIL params_ovf: got %b, required 0", ovf2);
      end
   endtask

   task automatic test_add_baseline;
      int cycles;
      int busy_cycles;
      set_all(8'd10, 8'd20);
      start_op(1'b0, 1'b0);
      busy_cycles = 0;
      cycles = -1;
      for (int i = 1; i <= 20; i++) begin
         if (busy) busy_cycles++;
         @(posedge clk);
         #1;
         if (done) begin
            cycles = i;
            break;
         end
      end
      assert_cnt++;
      if (cycles !== 5) begin
         fail_cnt++;
         $display("[TB] FAIL add_latency: got %0d, required 5", cycles);
      end
      assert_cnt++;
      if (busy_cycles !== 5 || busy !== 1'b0) begin
         fail_cnt++;
         $display("[TB] FAIL add_busy: busy cycles %0d busy_at_done %b, required 5 and 0",
                  busy_cycles, busy);
      end
      for (int e = 0; e < 25; e++) begin
         assert_cnt++;
         if (c_elem(e) !== 8'd30) begin
            fail_cnt++;
            $display("[TB] FAIL add_elem%0d: got %h, required 1e", e, c_elem(e));
         end
      end
      assert_cnt++;
      if (ovf !== 1'b0) begin
         fail_cnt++;
         $display("[TB] FAIL add_ovf: got %b, required 0", ovf);
      end
      @(posedge clk);
      #1;
      assert_cnt++;
      if (done !== 1'b0 || c_elem(3) !== 8'd30) begin
         fail_cnt++;
         $display("[TB] FAIL add_hold: done %b c3 %h, required 0 and 1e", done, c_elem(3));
      end
   endtask

   task automatic test_add_overflow(input logic sat_v);
      int cycles;
      logic [7:0] exp;
      set_all(8'd1, 8'd1);
      a_flat[7*8 +: 8] = 8'd100;
      b_flat[7*8 +: 8] = 8'd100;
      start_op(1'b0, sat_v);
      wait_done(cycles);
      assert_cnt++;
      if (cycles !== 5) begin
         fail_cnt++;
         $display("[TB] FAIL addovf_sat%0b_latency: got %0d, required 5", sat_v, cycles);
      end
      for (int e = 0; e < 25; e++) begin
         exp = (e == 7) ? (sat_v ? 8'h7F : 8'hC8) : 8'd2;
         assert_cnt++;
         if (c_elem(e) !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL addovf_sat%0b_elem%0d: got %h, required %h",
                     sat_v, e, c_elem(e), exp);
         end
      end
      assert_cnt++;
      if (ovf !== 1'b1) begin
         fail_cnt++;
         $display("[TB] FAIL addovf_sat%0b_flag: got %b, required 1", sat_v, ovf);
      end
   endtask

   task automatic test_sub(input logic sat_v);
      int cycles;
      logic [7:0] exp0;
      set_all(8'd0, 8'd0);
      a_flat[0 +: 8]    = 8'h80;
      b_flat[0 +: 8]    = 8'd1;
      a_flat[24*8 +: 8] = 8'd5;
      b_flat[24*8 +: 8] = 8'd3;
      start_op(1'b1, sat_v);
      wait_done(cycles);
      exp0 = sat_v ? 8'h80 : 8'h7F;
      assert_cnt++;
      if (cycles !== 5) begin
         fail_cnt++;
         $display("[TB] FAIL sub_sat%0b_latency: got %0d, required 5", sat_v, cycles);
      end
      assert_cnt++;
      if (c_elem(0) !== exp0) begin
         fail_cnt++;
         $display("[TB] FAIL sub_sat%0b_elem0: got %h, required %h", sat_v, c_elem(0), exp0);
      end
      assert_cnt++;
      if (c_elem(24) !== 8'd2) begin
         fail_cnt++;
         $display("[TB] FAIL sub_sat%0b_elem24: got %h, required 02", sat_v, c_elem(24));
      end
      assert_cnt++;
      if (c_elem(12) !== 8'd0) begin
         fail_cnt++;
         $display("[TB] FAIL sub_sat%0b_elem12: got %h, required 00", sat_v, c_elem(12));
      end
      assert_cnt++;
      if (ovf !== 1'b1) begin
         fail_cnt++;
         $display("[TB] FAIL sub_sat%0b_flag: got %b, required 1", sat_v, ovf);
      end
   endtask

   task automatic test_start_while_busy;
      int cycles;
      set_all(8'd10, 8'd20);
      start_op(1'b0, 1'b0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      set_all(8'd50, 8'd50);
      op     = 1'b1;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      wait_done(cycles);
      assert_cnt++;
      if (cycles !== 2) begin
         fail_cnt++;
         $display("[TB] FAIL busy_start_latency: got %0d more cycles, required 2", cycles);
      end
      for (int e = 0; e < 25; e += 6) begin
         assert_cnt++;
         if (c_elem(e) !== 8'd30) begin
            fail_cnt++;
            $display("[TB] FAIL busy_start_elem%0d: got %h, required 1e", e, c_elem(e));
         end
      end
   endtask

   task automatic test_back_to_back;
      int cycles;
      set_all(8'd1, 8'd1);
      a_flat[7*8 +: 8] = 8'd100;
      b_flat[7*8 +: 8] = 8'd100;
      start_op(1'b0, 1'b0);
      wait_done(cycles);
      assert_cnt++;
      if (done !== 1'b1 || ovf !== 1'b1) begin
         fail_cnt++;
         $display("[TB] FAIL b2b_first: done %b ovf %b, required 1 and 1", done, ovf);
      end
      set_all(8'd10, 8'd20);
      op     = 1'b0;
      sat_en = 1'b0;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      assert_cnt++;
      if (done !== 1'b0 || busy !== 1'b1 || ovf !== 1'b0) begin
         fail_cnt++;
         $display("[TB] FAIL b2b_accept: done %b busy %b ovf %b, required 0 1 0",
                  done, busy, ovf);
      end
      wait_done(cycles);
      assert_cnt++;
      if (cycles !== 5) begin
         fail_cnt++;
         $display("[TB] FAIL b2b_latency: got %0d, required 5", cycles);
      end
      assert_cnt++;
      if (c_elem(7) !== 8'd30 || ovf !== 1'b0) begin
         fail_cnt++;
         $display("[TB] FAIL b2b_result: c7 %h ovf %b, required 1e and 0", c_elem(7), ovf);
      end
   endtask

   task automatic test_reset_mid_op;
      int cycles;
      set_all(8'd1, 8'd1);
      a_flat[7*8 +: 8] = 8'd100;
      b_flat[7*8 +: 8] = 8'd100;
      start_op(1'b0, 1'b0);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      #1;
      assert_cnt++;
      if ({c_flat, ovf, busy, done} !== 203'd0) begin
         fail_cnt++;
         $display("[TB] FAIL midreset_outputs: c=%h ovf=%b busy=%b done=%b, required all 0",
                  c_flat, ovf, busy, done);
      end
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            @(negedge clk);
            rst_n = 1'b1;
         end
         @(posedge clk);
         #1;
         assert_cnt++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            fail_cnt++;
            $display("[TB] FAIL midreset_idle%0d: done %b busy %b, required 0 0", i, done, busy);
         end
      end
      set_all(8'd10, 8'd20);
      start_op(1'b0, 1'b0);
      wait_done(cycles);
      assert_cnt++;
      if (cycles !== 5 || c_elem(20) !== 8'd30 || ovf !== 1'b0) begin
         fail_cnt++;
         $display("[TB] FAIL midreset_restart: cycles %0d c20 %h ovf %b, required 5 1e 0",
                  cycles, c_elem(20), ovf);
      end
   endtask

   initial begin
      assert_cnt = 0;
      fail_cnt   = 0;
      test_reset;
      test_params;
      test_add_baseline;
      test_add_overflow(1'b0);
      test_add_overflow(1'b1);
      test_sub(1'b0);
      test_sub(1'b1);
      test_start_while_busy;
      test_back_to_back;
      test_reset_mid_op;
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/alu_addsub_seq_module.md
# alu_addsub_seq_module

Multi-cycle, parametrised matrix add/subtract unit for the arithmetic coprocessor. It processes `LANES` elements per clock over a flattened matrix of `ELEMS` signed elements of `DATA_W` bits each. It provides an add/sub mode select, optional saturation, a per-operation sticky overflow flag and a start/busy/done handshake. It sits in the ALU datapath beside the other matrix operation modules and is driven by the coprocessor control FSM.

## Interface
- `DATA_W`, default 8: element width in bits, two's complement.
- `ELEMS`, default 25: number of elements per matrix.
- `LANES`, default 5: elements computed per cycle, 1..ELEMS.
- Derived: `BEATS = ceil(ELEMS/LANES)`.

- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: operation request, sampled on a rising edge while idle.
- `op`, in, 1: 0 = C=A+B, 1 = C=A−B; captured on start.
- `sat_en`, in, 1: 1 = saturate on overflow, 0 = wrap; captured on start.
- `A_flat`, in, ELEMS*DATA_W: matrix A; element i at `[i*DATA_W +: DATA_W]`; captured on start.
- `B_flat`, in, ELEMS*DATA_W: matrix B, same layout; captured on start.
- `C_flat`, out, ELEMS*DATA_W: registered result, same layout.
- `overflow_flag`, out, 1: sticky; 1 if any element of the current/last op overflowed.
- `busy`, out, 1: operation in progress.
- `done`, out, 1: single-cycle pulse when `C_flat` and `overflow_flag` are final.

## Operation
- FSM states:
  - IDLE → RUN on `start`=1.
  - RUN → IDLE after beat `BEATS-1`.
- There is no other state.
- On accept:
  - A, B, `op` and `sat_en` are latched into internal registers, so inputs may change afterwards.
  - The beat counter is set to 0.
  - `overflow_flag` is cleared.
  - `busy` goes to 1.
- Each RUN cycle:
  - Beat k computes elements `k*LANES .. min(k*LANES+LANES, ELEMS)-1`.
  - Only those `C_flat` slices are written.
  - Lanes beyond `ELEMS` on the final partial beat are ignored and write nothing.
- Arithmetic per element:
  - Compute in DATA_W+1 bits.
  - Add overflow: a and b have the same sign and the result sign differs from a.
  - Sub overflow: a and b have different signs and the result sign differs from a.
  - Wrap mode: the result is the low DATA_W bits.
  - Saturate mode, on overflow: the result is `2^(DATA_W-1)-1` if a ≥ 0, else `-2^(DATA_W-1)`.
  - `overflow_flag` is ORed with each element's overflow in both modes.
- `start` while `busy`=1 is ignored; the latched operands are unaffected.
- `C_flat` during RUN holds a mix of new and previous slices and is valid only from `done` onward.
- After `done`, `C_flat` and `overflow_flag` hold until the next accepted start or reset.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE, beat counter 0.
  - `C_flat`, `overflow_flag`, `busy` and `done` all 0.
  - Latched operands are cleared to 0.
- Start accepted at edge E0: `busy`=1 after E0.
- Beat k result is registered at edge E(k+1).
- At E(BEATS):
  - The last slice is written.
  - `busy`→0 and `done`→1 for exactly one cycle.
- Latency is BEATS cycles from accept edge to `done` high. The default is 5.
- `start`=1 during the `done` cycle is accepted, because the block is IDLE:
  - `done` falls and `busy` rises on the same edge.
  - `overflow_flag` is cleared on that edge.
- `rst_n` low mid-RUN aborts the operation:
  - No `done` pulse is produced.
  - Outputs take their reset values.
  - Operation resumes only on a new `start` after reset release.
- With `LANES=ELEMS` (BEATS=1), `done` fires 1 cycle after accept.

## Test plan
- Add baseline (defaults): all A=8'd10, B=8'd20, op=0, sat_en=0.
  - Required: `done` exactly 5 cycles after accept, all C=8'd30, `overflow_flag`=0, `busy` high for 5 cycles.
- Add overflow on element 7: A=8'd100, B=8'd100, all other elements 1+1.
  - sat_en=0: C[7]=8'hC8, others 8'd2, `overflow_flag`=1.
  - sat_en=1: C[7]=8'h7F.
- Subtract, element 0 = 8'h80−8'd1, element 24 = 8'd5−8'd3.
  - sat_en=0: C[0]=8'h7F, flag 1.
  - sat_en=1: C[0]=8'h80, flag 1.
  - Both modes: C[24]=8'd2.
- Handshake:
  - `start` pulsed at beat 2 with different operands: ignored, result matches the first operands.
  - `start` asserted during the `done` cycle: accepted, flag cleared, second `done` 5 cycles later.
- Reset mid-op: deassert `rst_n` at beat 3.
  - Required: `C_flat`=0, flags 0, `busy`=0 immediately, no `done` pulse.
  - A fresh `start` afterwards completes normally.
- Parameters ELEMS=9, LANES=4 (BEATS=3), A[i]=i, B[i]=1.
  - Required: `done` 3 cycles after accept, C[i]=i+1 for i=0..8.
  - The final beat writes only element 8.
